// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file with pending-write scoreboard.
package regfile_pkg;

    localparam int          DATA_W_DEF = 32;
    localparam int          DEPTH_DEF  = 32;
    localparam int          ADDR_W_DEF = $clog2(DEPTH_DEF);
    localparam int unsigned ZERO_ADDR  = 0;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

    // A register index is writable/settable if it exists and is not the hardwired zero.
    function automatic logic addr_valid(input int unsigned addr,
                                        input int unsigned depth,
                                        input logic        zero_reg);
        return (addr < depth) && !(zero_reg && (addr == ZERO_ADDR));
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: hardwired-zero, range check, write bypass and busy masking.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic [ADDR_W-1:0]             addr,
    input  logic [DEPTH-1:0][DATA_W-1:0]  regs,
    input  logic [DEPTH-1:0]              busy_q,
    input  logic                          wr_en,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic [DATA_W-1:0]             data,
    output logic                          busy
);

    logic is_zero;
    logic in_range;
    logic forward;

    assign is_zero  = ZERO_REG && (32'(addr) == ZERO_ADDR);
    assign in_range = 32'(addr) < DEPTH;
    assign forward  = BYPASS && wr_en && (wr_addr == addr);

    // Zero register wins over the bypass; a forwarded operand is no longer pending.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        data = '0;
        busy = 1'b0;
        if (!is_zero && in_range) begin
            if (forward) begin
                data = wr_data;
            end else begin
                data = regs[addr];
                busy = busy_q[addr];
            end
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with write bypass and a per-register pending-write scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int NREAD    = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREAD*ADDR_W-1:0]   rd_addr,
    output logic [NREAD*DATA_W-1:0]   rd_data,
    output logic [NREAD-1:0]          rd_busy,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      sb_set,
    input  logic [ADDR_W-1:0]         sb_addr,
    input  logic                      sb_flush,
    output logic [DEPTH-1:0]          busy_vec
);

    logic [DEPTH-1:0][DATA_W-1:0] regs_q;
    logic [DEPTH-1:0]             busy_q;
    logic [DEPTH-1:0]             busy_d;
    logic                         wr_valid;
    logic                         sb_valid;
    logic                         wr_in_range;

    assign wr_valid    = wr_en && addr_valid(32'(wr_addr), DEPTH, ZERO_REG);
    assign sb_valid    = sb_set && addr_valid(32'(sb_addr), DEPTH, ZERO_REG);
    assign wr_in_range = 32'(wr_addr) < DEPTH;

    // Data array. A flush squashes issue, not writeback, so the write always lands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the array is reset because the reset state must read as all zeros;
            // a RAM-style array without reset would not give that.
            regs_q <= '0;
        end else if (wr_valid) begin
            // NOTE: state is updated with <= so every flop samples pre-edge values.
            regs_q[wr_addr] <= wr_data;
        end
    end

    // Scoreboard next state: writeback clears, issue sets over it, flush clears everything.
    always_comb begin
        busy_d = busy_q;
        if (wr_en && wr_in_range) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (sb_valid) begin
            busy_d[sb_addr] = 1'b1;
        end
        if (sb_flush) begin
            busy_d = '0;
        end
        if (ZERO_REG) begin
            busy_d[ZERO_ADDR] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    for (genvar k = 0; k < NREAD; k++) begin : g_port
        rf_read_port #(
            .DATA_W   (DATA_W),
            .DEPTH    (DEPTH),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_port (
            .addr    (rd_addr[k*ADDR_W +: ADDR_W]),
            .regs    (regs_q),
            .busy_q  (busy_q),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .data    (rd_data[k*DATA_W +: DATA_W]),
            .busy    (rd_busy[k])
        );
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-read-port register file with a built-in pending-write scoreboard, for the pipelined CPU datapath.
- Adds configurable width, depth, read-port count and optional hardwired-zero register. Keeps write-to-read bypass.
- Tracks, per register, whether an issued instruction has yet to write back, so the ID-stage hazard unit can stall on busy operands.
- Sits in ID: read ports feed operand latches, the write port is driven from WB, and the scoreboard set port is driven at issue.

Parameters:
- DATA_W, 32: register width in bits.
- DEPTH, 32: number of registers.
- ADDR_W, $clog2(DEPTH): address width.
- NREAD, 2: number of independent read ports.
- ZERO_REG, 1: 1 means register 0 reads as 0, ignores writes and is never busy.
- BYPASS, 1: 1 means a same-cycle write is forwarded to matching reads.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- rd_addr  in  NREAD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NREAD*DATA_W  packed read data, combinational.
- rd_busy  out  NREAD  per-port "operand pending" flag, combinational.
- wr_en  in  1  writeback strobe.
- wr_addr  in  ADDR_W  writeback register.
- wr_data  in  DATA_W  writeback data.
- sb_set  in  1  issue strobe: mark sb_addr as pending.
- sb_addr  in  ADDR_W  destination register of the issuing instruction.
- sb_flush  in  1  clear all pending marks (pipeline squash).
- busy_vec  out  DEPTH  registered scoreboard state, for debug and hazard unit.

Behaviour:
- Reset (reset=0, asynchronous): all registers become 0; busy_vec becomes 0.
  - rd_data therefore reads 0 for every address.
  - rd_busy reads 0 on every port.
- Write path:
  - On clk rising edge, if wr_en=1 and wr_addr is valid, the register is loaded with wr_data.
  - "Valid" means wr_addr < DEPTH, and wr_addr != 0 when ZERO_REG=1.
  - Invalid writes are silently dropped.
- Read path (per port k, purely combinational, zero latency):
  - If ZERO_REG=1 and addr=0: output 0. This check has priority over the bypass.
  - Else if addr >= DEPTH: output 0.
  - Else if BYPASS=1, wr_en=1 and wr_addr=addr: output wr_data.
  - Else: output the stored value.
- rd_busy[k]:
  - Equals busy_q[addr], except it is forced to 0 when BYPASS=1, wr_en=1 and wr_addr=addr, because the value is being forwarded this cycle.
  - Forced to 0 for a zero or out-of-range addr.
  - Reflects registered state only; a same-cycle sb_set does not affect it.
- Scoreboard next-state, applied in this priority order, highest last:
  - 1) Start from the current busy bits.
  - 2) If wr_en=1, clear bit wr_addr.
  - 3) If sb_set=1 and sb_addr is valid, set bit sb_addr. Set overrides clear when wr_addr=sb_addr, because the new instruction is still pending.
  - 4) If sb_flush=1, all bits become 0. The flush overrides a same-cycle set, because the issuing instruction is squashed.
  - The write to the data array itself is NOT blocked by a flush.
- Busy bit 0 is held at 0 when ZERO_REG=1.
- Multiple set of an already-busy register keeps it busy. There is no counting; the pipeline guarantees in-order writeback per register.
- Reset asserted mid-cycle clears data and scoreboard immediately. Outputs follow combinationally.
- Reset deassertion is synchronised externally; the block needs no internal release logic.

Decomposition:
- Shared package regfile_pkg: DATA_W/DEPTH defaults, the ZERO_ADDR constant, and a typedef for the register address.
- One natural sub-module: rf_read_port, the bypass, zero and range mux for one port. It is instantiated NREAD times via generate.
- The scoreboard stays inline in regfile_sb.

Test Plan:
- Reset then read: after reset=0→1, read addresses 0, 5 and 31 on both ports → rd_data=0 and rd_busy=0 on all.
- Write then read: wr_en with wr_addr=5 and wr_data=0xDEADBEEF; next cycle rd_addr=5 → 0xDEADBEEF. A write to r0 with 0x1234 → r0 still reads 0.
- Bypass: in the same cycle, wr_en with wr_addr=7 and wr_data=0xA5A5A5A5, and rd_addr=7 on port1 → port1 shows 0xA5A5A5A5 combinationally.
  - The same test with BYPASS=0 → port1 shows the old value.
- Scoreboard lifecycle:
  - sb_set with sb_addr=3 → next cycle busy_vec[3]=1 and rd_busy=1 for addr 3.
  - wr_en with wr_addr=3 → rd_busy=0 in the same cycle, and busy_vec[3]=0 the next cycle.
- Simultaneous events:
  - wr_en with wr_addr=4 together with sb_set with sb_addr=4 → busy_vec[4]=1 afterwards.
  - sb_set with sb_addr=9 together with sb_flush → busy_vec all 0.
  - sb_set with sb_addr=0 → busy_vec[0] stays 0.
- Parametrisation and async reset: DEPTH=24, NREAD=3, DATA_W=64.
  - Read addr 30 → 0 and not busy.
  - Assert reset mid-cycle while r5 is busy with 0x1 → data and busy clear immediately, without waiting for a clock.
